// File: rtl/pv2stall_muldiv_arbiter.sv
// Arbitrates two requesters onto one in-order pipelined mul/div unit and routes each response
// back to its issuer via an in-order tag FIFO. Define PV2STALL_MULDIV_ARB_FIXED_PRIO_EN for fixed priority.

module pv2stall_muldiv_arbiter #(
    parameter int p_max_inflight = 8
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [66:0]                       req0_msg,
    input  logic                              req0_val,
    output logic                              req0_rdy,
    input  logic [66:0]                       req1_msg,
    input  logic                              req1_val,
    output logic                              req1_rdy,

    output logic [63:0]                       resp0_msg,
    output logic                              resp0_val,
    input  logic                              resp0_rdy,
    output logic [63:0]                       resp1_msg,
    output logic                              resp1_val,
    input  logic                              resp1_rdy,

    output logic [66:0]                       mdreq_msg,
    output logic                              mdreq_val,
    input  logic                              mdreq_rdy,
    input  logic [63:0]                       mdresp_msg,
    input  logic                              mdresp_val,
    output logic                              mdresp_rdy,

    output logic [$clog2(p_max_inflight):0]   inflight
);

    localparam int PTR_W = $clog2(p_max_inflight);
    localparam int CNT_W = PTR_W + 1;

    logic [p_max_inflight-1:0] tags;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    logic winner;
    logic full;
    logic nonempty;
    logic head;
    logic push;
    logic pop;

`ifdef PV2STALL_MULDIV_ARB_FIXED_PRIO_EN
    assign winner = ~req0_val & req1_val;
`else
    logic prio;

    // Preferred requester wins if valid; otherwise the other one. Idle cycles default to req0.
    assign winner = prio ? req1_val : (~req0_val & req1_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prio <= 1'b0;
        else if (push)
            prio <= ~winner;
    end
`endif

    assign full     = (count == CNT_W'(p_max_inflight));
    assign nonempty = (count != '0);
    assign head     = tags[rd_ptr];

    // Reset gates every handshake output so nothing fires while the unit is being flushed.
    assign mdreq_val = ~reset & (req0_val | req1_val) & ~full;
    assign mdreq_msg = winner ? req1_msg : req0_msg;
    assign req0_rdy  = ~reset & ~winner & mdreq_rdy & ~full;
    assign req1_rdy  = ~reset &  winner & mdreq_rdy & ~full;

    assign resp0_val  = ~reset & mdresp_val & nonempty & ~head;
    assign resp1_val  = ~reset & mdresp_val & nonempty &  head;
    assign resp0_msg  = mdresp_msg;
    assign resp1_msg  = mdresp_msg;
    assign mdresp_rdy = ~reset & nonempty & (head ? resp1_rdy : resp0_rdy);

    assign inflight = count;

    assign push = mdreq_val & mdreq_rdy;
    assign pop  = mdresp_val & mdresp_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: tag storage is deliberately not reset; only slots between rd_ptr and wr_ptr are ever
    // read, and clearing count on reset makes every stale tag unreachable.
    always_ff @(posedge clk) begin
        if (push)
            tags[wr_ptr] <= winner;
    end

endmodule
